// File: rtl/vote_tally_scheduler.sv
// Sequences the vote accumulator: round-robin whole-ballot intake from N_SRC
// sources, block-by-block tally readout on request, then accumulator re-init.
module vote_tally_scheduler #(
  parameter int REGISTER_SIZE   = 32,
  parameter int NUM_BITS_STORED = 4096,
  parameter int N_SRC           = 2,
  parameter int MAX_BALLOTS     = 1023,
  localparam int NUM_BLOCKS     = NUM_BITS_STORED / REGISTER_SIZE,
  localparam int CW             = $clog2(MAX_BALLOTS + 1)
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic [N_SRC*REGISTER_SIZE-1:0] src_block_in,
  input  logic [N_SRC-1:0]           src_valid_in,
  output logic [N_SRC-1:0]           src_ready_out,
  input  logic                       tally_req_in,
  output logic [REGISTER_SIZE-1:0]   acc_block_out,
  output logic                       acc_valid_out,
  output logic                       acc_compute_tally_out,
  output logic                       acc_request_next_out,
  input  logic [REGISTER_SIZE-1:0]   acc_data_in,
  input  logic                       acc_valid_in,
  output logic [REGISTER_SIZE-1:0]   tally_block_out,
  output logic                       tally_valid_out,
  output logic                       tally_last_out,
  output logic [CW-1:0]              ballot_count_out,
  output logic                       full_out,
  output logic                       busy_out
);

  localparam int SW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int BW = $clog2(NUM_BLOCKS + 1);
  localparam int KW = $clog2(NUM_BLOCKS + 4);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BALLOT,
    S_DRAIN_REQ,
    S_DRAIN_WAIT,
    S_CLEAR
  } state_t;

  state_t                   r_state;
  logic [SW-1:0]            r_rr;
  logic [SW-1:0]            r_gidx;
  logic [N_SRC-1:0]         r_grant;
  logic [BW-1:0]            r_blk_cnt;
  logic [KW-1:0]            r_clr_cnt;
  logic [CW-1:0]            r_ballot_cnt;
  logic                     r_pending;
  logic                     r_wait_armed;
  logic [REGISTER_SIZE-1:0] r_acc_block;
  logic                     r_acc_valid;
  logic                     r_req_next;
  logic                     r_compute;
  logic [REGISTER_SIZE-1:0] r_tally_block;
  logic                     r_tally_valid;
  logic                     r_tally_last;

  int                       w_idx;
  logic                     w_any;
  logic [SW-1:0]            w_gidx;
  logic [N_SRC-1:0]         w_onehot;
  logic [SW-1:0]            w_rr_next;
  logic                     w_full;
  logic                     w_xfer;
  logic [REGISTER_SIZE-1:0] w_sel_block;

  // Round-robin search: walk downward so the source closest to r_rr wins.
  always_comb begin
    w_idx    = 0;
    w_any    = 1'b0;
    w_gidx   = '0;
    w_onehot = '0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      w_idx = (int'(r_rr) + k) % N_SRC;
      if (src_valid_in[SW'(w_idx)]) begin
        w_any  = 1'b1;
        w_gidx = SW'(w_idx);
      end
    end
    w_onehot[w_gidx] = 1'b1;
  end

  assign w_rr_next   = (r_gidx == SW'(N_SRC - 1)) ? '0 : r_gidx + 1'b1;
  assign w_full      = (r_ballot_cnt == CW'(MAX_BALLOTS));
  assign w_xfer      = (r_state == S_BALLOT) && |(r_grant & src_valid_in);
  assign w_sel_block = src_block_in[r_gidx*REGISTER_SIZE +: REGISTER_SIZE];

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state       <= S_IDLE;
      r_rr          <= '0;
      r_gidx        <= '0;
      r_grant       <= '0;
      r_blk_cnt     <= '0;
      r_clr_cnt     <= '0;
      r_ballot_cnt  <= '0;
      r_pending     <= 1'b0;
      r_wait_armed  <= 1'b0;
      r_acc_block   <= '0;
      r_acc_valid   <= 1'b0;
      r_req_next    <= 1'b0;
      r_compute     <= 1'b0;
      r_tally_block <= '0;
      r_tally_valid <= 1'b0;
      r_tally_last  <= 1'b0;
    end else begin
      r_acc_valid   <= 1'b0;
      r_req_next    <= 1'b0;
      r_compute     <= 1'b0;
      r_tally_valid <= 1'b0;
      r_tally_last  <= 1'b0;
      r_pending     <= r_pending | tally_req_in;
      case (r_state)
        S_IDLE: begin
          if (r_pending || tally_req_in) begin
            r_state    <= S_DRAIN_REQ;
            r_req_next <= 1'b1;
            r_blk_cnt  <= '0;
          end else if (!w_full && w_any) begin
            r_state   <= S_BALLOT;
            r_grant   <= w_onehot;
            r_gidx    <= w_gidx;
            r_blk_cnt <= '0;
          end
        end
        S_BALLOT: begin
          if (w_xfer) begin
            r_acc_block <= w_sel_block;
            r_acc_valid <= 1'b1;
            if (r_blk_cnt == BW'(NUM_BLOCKS - 1)) begin
              r_blk_cnt <= '0;
              r_grant   <= '0;
              r_rr      <= w_rr_next;
              r_state   <= S_IDLE;
              if (!w_full) r_ballot_cnt <= r_ballot_cnt + 1'b1;
            end else begin
              r_blk_cnt <= r_blk_cnt + 1'b1;
            end
          end
        end
        S_DRAIN_REQ: begin
          r_state      <= S_DRAIN_WAIT;
          r_wait_armed <= 1'b0;
        end
        S_DRAIN_WAIT: begin
          // The accumulator cannot answer in the cycle right after the request.
          if (!r_wait_armed) begin
            r_wait_armed <= 1'b1;
          end else if (acc_valid_in) begin
            r_tally_block <= acc_data_in;
            r_tally_valid <= 1'b1;
            if (r_blk_cnt == BW'(NUM_BLOCKS - 1)) begin
              r_tally_last <= 1'b1;
              r_compute    <= 1'b1;
              r_clr_cnt    <= '0;
              r_blk_cnt    <= '0;
              r_state      <= S_CLEAR;
            end else begin
              r_blk_cnt  <= r_blk_cnt + 1'b1;
              r_req_next <= 1'b1;
              r_state    <= S_DRAIN_REQ;
            end
          end
        end
        S_CLEAR: begin
          // One pulse cycle plus NUM_BLOCKS+3 cycles of accumulator rewrite.
          if (r_clr_cnt == KW'(NUM_BLOCKS + 3)) begin
            r_ballot_cnt <= '0;
            r_pending    <= 1'b0;
            r_state      <= S_IDLE;
          end else begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign src_ready_out         = r_grant;
  assign acc_block_out         = r_acc_block;
  assign acc_valid_out         = r_acc_valid;
  assign acc_compute_tally_out = r_compute;
  assign acc_request_next_out  = r_req_next;
  assign tally_block_out       = r_tally_block;
  assign tally_valid_out       = r_tally_valid;
  assign tally_last_out        = r_tally_last;
  assign ballot_count_out      = r_ballot_cnt;
  assign full_out              = w_full;
  assign busy_out              = (r_state != S_IDLE);

endmodule

// File: doc/vote_tally_scheduler.md
# vote_tally_scheduler

Controller that sequences the vote accumulator. It arbitrates ballot ciphertext streams from N_SRC intake sources into the accumulator one whole ballot at a time. On request it drains the accumulated tally block by block, then pulses `compute_tally` to reinitialise the accumulator. It sits between the ballot intake paths (UART/ethernet decoders) and the accumulator, and drives every accumulator control input.

## Interface
- `REGISTER_SIZE`, 32, width of one block.
- `NUM_BITS_STORED`, 4096, ciphertext/tally width; NUM_BLOCKS = NUM_BITS_STORED/REGISTER_SIZE.
- `N_SRC`, 2, number of ballot sources (≥2).
- `MAX_BALLOTS`, 1023, ballots accepted per tally period; CW = $clog2(MAX_BALLOTS+1).
- `clk_in` in 1: single clock, all logic on posedge.
- `rst_in` in 1: asynchronous, active-low reset.
- `src_block_in` in N_SRC*REGISTER_SIZE: source s occupies bits [s*REGISTER_SIZE +: REGISTER_SIZE].
- `src_valid_in` in N_SRC: block valid per source.
- `src_ready_out` out N_SRC: one-hot grant; a block transfers on valid&ready.
- `tally_req_in` in 1: one-cycle pulse requesting tally readout.
- `acc_block_out` out REGISTER_SIZE: block to accumulator `block_in`.
- `acc_valid_out` out 1: to accumulator `valid_in`.
- `acc_compute_tally_out` out 1: to accumulator `compute_tally`.
- `acc_request_next_out` out 1: to accumulator `request_next_in`.
- `acc_data_in` in REGISTER_SIZE: accumulator `data_out`.
- `acc_valid_in` in 1: accumulator `valid_out`.
- `tally_block_out` out REGISTER_SIZE: drained tally block.
- `tally_valid_out` out 1: one-cycle strobe per tally block.
- `tally_last_out` out 1: high with the final (NUM_BLOCKS-th) strobe.
- `ballot_count_out` out CW: ballots fully accepted this period.
- `full_out` out 1: ballot_count_out == MAX_BALLOTS.
- `busy_out` out 1: state != IDLE.

## Operation
- States: IDLE, BALLOT, DRAIN_REQ, DRAIN_WAIT, CLEAR.
- IDLE:
  - A pending tally request takes priority and moves to DRAIN_REQ.
  - Otherwise, if !full_out and any src_valid_in is set, grant by round-robin from pointer rr, move to BALLOT and set src_ready_out to the one-hot grant.
  - After reset rr=0.
  - After each completed ballot, rr = granted+1 mod N_SRC.
- BALLOT:
  - The grant is locked for NUM_BLOCKS transfers.
  - The source may drop valid mid-ballot; the controller stalls and holds the grant.
  - Each transfer registers block→acc_block_out and sets acc_valid_out=1 the next cycle; otherwise acc_valid_out=0.
  - After the NUM_BLOCKS-th transfer: src_ready_out=0, ballot_count+1, return to IDLE.
- tally_req_in:
  - Latched into `pending` in any state.
  - It never interrupts a ballot in progress.
  - A second pulse while pending is absorbed.
- DRAIN_REQ: pulse acc_request_next_out for one cycle, then go to DRAIN_WAIT.
- DRAIN_WAIT:
  - Ignore acc_valid_in in the first cycle after the request pulse.
  - From then on, the first cycle with acc_valid_in=1 captures acc_data_in into tally_block_out, with tally_valid_out=1 for one cycle.
  - Increment the block counter. If it reaches NUM_BLOCKS, assert tally_last_out with that strobe and go to CLEAR; else return to DRAIN_REQ.
- CLEAR:
  - Pulse acc_compute_tally_out for one cycle, then hold for NUM_BLOCKS+3 cycles (accumulator rewrite time).
  - Then clear ballot_count and pending, and return to IDLE.
- Counters: ballot_count never exceeds MAX_BALLOTS. When full, IDLE issues no grants, but a tally is still served.

## Timing
- Reset (rst_in=0, immediate and asynchronous): all outputs 0; state IDLE; rr=0; counters 0; pending=0.
- Reset mid-ballot or mid-drain discards the partial transfer; no strobes follow.
- Grant: src_ready_out rises the cycle after IDLE sees valid (1-cycle arbitration latency).
- Data path: acc_valid_out/acc_block_out follow the transfer by exactly 1 cycle. Maximum throughput is 1 block/cycle within a ballot.
- Ballot gap: 1 idle cycle (IDLE) between consecutive ballots.
- Drain: request pulse at t; the earliest capture is at t+2. With the accumulator's 3-cycle response, each block takes 4 cycles.
- Tally request arriving the same cycle a ballot completes: the completed ballot is counted, and the next state is DRAIN_REQ via IDLE.
- Simultaneous valid on all sources: exactly one grant; others wait for a later IDLE.

## Test plan
Benches use NUM_BITS_STORED=128 (NUM_BLOCKS=4), N_SRC=2, MAX_BALLOTS=3.
- **Single ballot:** source0 sends 4 blocks 0x11..0x14 back-to-back -> acc_valid_out high 4 consecutive cycles, 1 cycle after each transfer, values in order; ballot_count_out=1.
- **Contention:** both sources valid continuously -> grants alternate 0,1,0. After 3 ballots full_out=1 and src_ready_out stays 0 thereafter.
- **Stall:** source1 drops valid for 5 cycles after block 2 -> grant held, no acc_valid_out during the gap, 4 blocks total delivered.
- **Tally mid-ballot:** tally_req_in pulse during block 2 -> ballot finishes first. Then 4 request pulses and 4 tally_valid_out strobes (model returns 0xA0..0xA3), tally_last_out on 0xA3. Then one acc_compute_tally_out pulse; ballot_count_out=0 after CLEAR.
- **Reset mid-drain:** assert rst_in=0 after 2nd tally strobe -> all outputs 0 immediately. After release, no further strobes; a new ballot is accepted from source0.
